// File: rtl/dram_lut_lookup_sched.sv
`default_nettype none
// ============================================================================
// Module      : dram_lut_lookup_sched
// Description : Schedules a block of S-box lookup bytes onto parallel DRAM
//               cores over several read passes. It also handles read
//               completion or timeout and returns the looked-up block.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_lut_lookup_sched #(
  parameter int NUM_BYTES = 16,
  parameter int NUM_CORES = 16,
  parameter int TIMEOUT   = 64,
  parameter int TMR_W     = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req_vld,
  output logic                   req_rdy,
  input  logic [NUM_BYTES*8-1:0] req_bytes,
  input  logic                   req_mode,
  output logic                   rsp_vld,
  input  logic                   rsp_rdy,
  output logic [NUM_BYTES*8-1:0] rsp_bytes,
  output logic                   rsp_err,
  output logic [NUM_CORES*6-1:0] core_rwl_add,
  output logic [NUM_CORES*3-1:0] core_demux_add,
  output logic                   core_rd_en,
  input  logic                   core_rd_done,
  input  logic [NUM_CORES*8-1:0] core_rd_data,
  output logic                   busy,
  output logic                   trigger
);

  localparam int P  = NUM_BYTES / NUM_CORES;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int PB = NUM_CORES * 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [NUM_BYTES*8-1:0] bytes_q;
  logic                   mode_q;
  logic [PW-1:0]          pass_q;
  logic                   err_q;
  logic [TMR_W-1:0]       tmr_q;
  logic [NUM_BYTES*8-1:0] rsp_q;
  logic [NUM_CORES*6-1:0] rwl_q, rwl_d;
  logic [NUM_CORES*3-1:0] demux_q, demux_d;
  logic                   trig_q;

  logic                   accept;
  logic                   tmo;
  logic                   fin;
  logic                   last;
  logic                   load_addr;
  logic [NUM_BYTES*8-1:0] sel_src;
  logic                   sel_mode;
  logic [PW-1:0]          sel_pass;
  logic [PB-1:0]          pass_bytes;

  // Pass completion, timeout detection and next-state selection
  always_comb begin
    accept    = (state_q == S_IDLE) && req_vld;
    tmo       = (TIMEOUT != 0) && (tmr_q == TMR_W'(TIMEOUT - 1));
    fin       = (state_q == S_WAIT) && (core_rd_done || tmo);
    last      = (pass_q == PW'(P - 1));
    load_addr = accept || (fin && !last);
    state_d   = state_q;
    case (state_q)
      S_IDLE:  if (req_vld) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (fin) state_d = last ? S_DONE : S_ISSUE;
      S_DONE:  if (rsp_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address generation for the pass about to be issued; on accept the
  // request is not latched yet, so the live request bus is used
  always_comb begin
    sel_src  = bytes_q;
    sel_mode = mode_q;
    sel_pass = pass_q + 1'b1;
    if (state_q == S_IDLE) begin
      sel_src  = req_bytes;
      sel_mode = req_mode;
      sel_pass = '0;
    end
    pass_bytes = '0;
    for (int p = 0; p < P; p++) begin
      if (sel_pass == PW'(p)) pass_bytes = sel_src[p*PB +: PB];
    end
    rwl_d   = '0;
    demux_d = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      rwl_d[6*i +: 6]   = pass_bytes[8*i+2 +: 6];
      demux_d[3*i +: 3] = {sel_mode, pass_bytes[8*i +: 2]};
    end
  end

  // State, request latch, pass results and registered core addresses
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      bytes_q <= '0;
      mode_q  <= 1'b0;
      pass_q  <= '0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      rsp_q   <= '0;
      rwl_q   <= '0;
      demux_q <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        bytes_q <= req_bytes;
        mode_q  <= req_mode;
        pass_q  <= '0;
        err_q   <= 1'b0;
        trig_q  <= 1'b1;
      end
      if (state_q == S_ISSUE) tmr_q <= '0;
      if (state_q == S_WAIT)  tmr_q <= tmr_q + 1'b1;
      if (fin) begin
        // A read completion in the timeout cycle takes precedence
        for (int p = 0; p < P; p++) begin
          if (pass_q == PW'(p)) rsp_q[p*PB +: PB] <= core_rd_done ? core_rd_data : '0;
        end
        if (!core_rd_done) err_q <= 1'b1;
        if (last) trig_q <= 1'b0;
        else      pass_q <= pass_q + 1'b1;
      end
      if (load_addr) begin
        rwl_q   <= rwl_d;
        demux_q <= demux_d;
      end
    end
  end

  assign req_rdy        = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign rsp_vld        = (state_q == S_DONE);
  assign core_rd_en     = (state_q == S_ISSUE);
  assign rsp_bytes      = rsp_q;
  assign rsp_err        = err_q;
  assign core_rwl_add   = rwl_q;
  assign core_demux_add = demux_q;
  assign trigger        = trig_q;

endmodule
`default_nettype wire
